// File: rtl/alm_share_arbiter.sv
// Round-robin shared DR_ALM approximate log multiplier with a 2-stage pipeline and full backpressure.
// Optional build macro ALM_ZERO_SKIP_EN forces the product to 0 when either operand is zero.

module dr_alm #(
    parameter int W       = 8,
    parameter int MULT_DW = 5,
    parameter int PW      = 16
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [PW-1:0] p
);
    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam int EW = KW + 2;
    localparam int XW = MULT_DW + 1 + 2 * W;

    logic [KW-1:0]          ka, kb;
    logic [W+MULT_DW-2:0]   sa, sb;
    logic [MULT_DW-1:0]     xa, xb;
    logic [MULT_DW:0]       fsum;
    logic [EW-1:0]          exp_sum;

    function automatic logic [KW-1:0] lead_one(input logic [W-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) k = KW'(i);
        end
        return k;
    endfunction

    always_comb begin
        ka = lead_one(a);
        kb = lead_one(b);
        // Left-align the leading one so the bits beneath it become the mantissa fraction.
        sa = {a, {(MULT_DW-1){1'b0}}} << (KW'(W-1) - ka);
        sb = {b, {(MULT_DW-1){1'b0}}} << (KW'(W-1) - kb);
        // Truncated fraction with the LSB forced high to centre the truncation error.
        xa = {(MULT_DW-1)'(sa >> (W-1)), 1'b1};
        xb = {(MULT_DW-1)'(sb >> (W-1)), 1'b1};
        fsum = {1'b0, xa} + {1'b0, xb};
        exp_sum = EW'(ka) + EW'(kb) + EW'(fsum[MULT_DW]);
        p = PW'((XW'({1'b1, fsum[MULT_DW-1:0]}) << exp_sum) >> MULT_DW);
    end
endmodule

module alm_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int A_BW    = 8,
    parameter int B_BW    = 8,
    parameter int MULT_DW = 5,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*A_BW-1:0] req_a,
    input  logic [NREQ*B_BW-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [A_BW+B_BW-1:0] rsp_p,
    output logic [1:0]           inflight
);
    localparam int W  = (A_BW > B_BW) ? A_BW : B_BW;
    localparam int PW = A_BW + B_BW;

    logic            s1_valid_q, s1_valid_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic [W-1:0]    s1_a_q, s1_a_d;
    logic [W-1:0]    s1_b_q, s1_b_d;
    logic            s2_valid_q, s2_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [PW-1:0]   rsp_p_q, rsp_p_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
`ifdef ALM_ZERO_SKIP_EN
    logic            s1_zero_q, s1_zero_d;
`endif

    logic            adv1, adv2;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand;
    logic [A_BW-1:0] sel_a;
    logic [B_BW-1:0] sel_b;
    logic [PW-1:0]   mult_p;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    assign adv2 = !s2_valid_q || rsp_ready;
    assign adv1 = !s1_valid_q || adv2;

    // Scan starts at rr_ptr so the most recently served requester has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand = wrap_idx(rr_ptr_q, j);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (adv1 && grant_found) req_ready[grant_id] = 1'b1;
    end

    assign sel_a = req_a[int'(grant_id)*A_BW +: A_BW];
    assign sel_b = req_b[int'(grant_id)*B_BW +: B_BW];

    dr_alm #(.W(W), .MULT_DW(MULT_DW), .PW(PW)) u_mult (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mult_p)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        rr_ptr_d   = rr_ptr_q;
        s2_valid_d = s2_valid_q;
        rsp_id_d   = rsp_id_q;
        rsp_p_d    = rsp_p_q;
`ifdef ALM_ZERO_SKIP_EN
        s1_zero_d  = s1_zero_q;
`endif
        if (adv1) begin
            s1_valid_d = grant_found;
            if (grant_found) begin
                s1_id_d  = grant_id;
                s1_a_d   = W'(sel_a);
                s1_b_d   = W'(sel_b);
                rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
`ifdef ALM_ZERO_SKIP_EN
                s1_zero_d = (sel_a == '0) || (sel_b == '0);
`endif
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_id_d = s1_id_q;
`ifdef ALM_ZERO_SKIP_EN
                rsp_p_d  = s1_zero_q ? '0 : mult_p;
`else
                rsp_p_d  = mult_p;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            rsp_id_q   <= '0;
            rsp_p_q    <= '0;
            rr_ptr_q   <= '0;
`ifdef ALM_ZERO_SKIP_EN
            s1_zero_q  <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            rsp_id_q   <= rsp_id_d;
            rsp_p_q    <= rsp_p_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef ALM_ZERO_SKIP_EN
            s1_zero_q  <= s1_zero_d;
`endif
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign inflight  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
endmodule

// File: tb/tb_alm_share_arbiter.sv
// Self-checking bench for alm_share_arbiter: scenario tasks plus an expected-queue scoreboard
// fed from an independent integer model of the DR_ALM multiplier.

module tb_alm_share_arbiter;
    localparam int NREQ = 4;
    localparam int A_BW = 8;
    localparam int B_BW = 8;
    localparam int M    = 5;
    localparam int IDW  = 2;
    localparam int PW   = 16;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*A_BW-1:0] req_a;
    logic [NREQ*B_BW-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [PW-1:0]        rsp_p;
    logic [1:0]           inflight;

    int checks = 0;
    int errors = 0;
    logic [IDW+PW-1:0] exp_q[$];
    logic [NREQ-1:0]   acc_vec = '0;

    alm_share_arbiter #(.NREQ(NREQ), .A_BW(A_BW), .B_BW(B_BW), .MULT_DW(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .inflight  (inflight)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Integer reference of the truncated Mitchell multiplier.
    function automatic logic [PW-1:0] golden(input int a, input int b);
        int ka, kb, fa, fb, s, e;
        longint p;
        ka = 0;
        kb = 0;
        for (int i = 0; i < 8; i++) begin
            if (((a >> i) & 1) == 1) ka = i;
            if (((b >> i) & 1) == 1) kb = i;
        end
        fa = (a == 0) ? 0 : (((a - (1 << ka)) << (M - 1)) >> ka);
        fb = (b == 0) ? 0 : (((b - (1 << kb)) << (M - 1)) >> kb);
        s = (fa * 2 + 1) + (fb * 2 + 1);
        e = ka + kb;
        if (s >= (1 << M)) begin
            s = s - (1 << M);
            e = e + 1;
        end
        p = (longint'((1 << M) + s) << e) >> M;
        return p[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] expect_p(input logic [7:0] a, input logic [7:0] b);
`ifdef ALM_ZERO_SKIP_EN
        if (a == 8'd0 || b == 8'd0) return '0;
`endif
        return golden(int'(a), int'(b));
    endfunction

    // scoreboard: push at accept, pop at retire, both sampled mid-cycle
    initial begin
        logic [IDW+PW-1:0] exp_item;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_vec = '0;
            end else begin
                if (rsp_valid && rsp_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_extra: got id=%0d p=%0d, expected no response", rsp_id, rsp_p);
                    end else begin
                        exp_item = exp_q.pop_front();
                        if ({rsp_id, rsp_p} !== exp_item) begin
                            errors++;
                            $display("FAIL scoreboard_rsp: got id=%0d p=%0d, expected id=%0d p=%0d",
                                     rsp_id, rsp_p, exp_item[IDW+PW-1:PW], exp_item[PW-1:0]);
                        end
                    end
                end
                acc_vec = req_valid & req_ready;
                for (int i = 0; i < NREQ; i++) begin
                    if (acc_vec[i]) exp_q.push_back({2'(i), expect_p(req_a[i*A_BW +: A_BW], req_b[i*B_BW +: B_BW])});
                end
            end
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*A_BW +: A_BW] = a;
        req_b[i*B_BW +: B_BW] = b;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while ((inflight != 2'd0) && n < 20) begin
            next_cycle();
            n++;
        end
        checks++;
        if (inflight !== 2'd0) begin
            errors++;
            $display("FAIL drain_timeout: inflight=%0d, expected 0", inflight);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        next_cycle();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        checks++;
        if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
        checks++;
        if (rsp_id !== 2'd0 || rsp_p !== 16'd0) begin errors++; $display("FAIL reset_rsp_data: got id=%0d p=%0d expected 0/0", rsp_id, rsp_p); end
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_rdy;
        randomize_ops();
        set_op(0, 8'd100, 8'd37);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, exp_rdy);
            end
            if (c >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4)) begin
                    errors++;
                    $display("FAIL rr_rsp_id c=%0d: got valid=%0b id=%0d expected valid=1 id=%0d", c, rsp_valid, rsp_id, (c - 2) % 4);
                end
            end
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (acc_vec[i]) set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            if (c == 7) req_valid = '0;
        end
        drain();
    endtask

    task automatic test_backpressure();
        int n;
        logic [IDW-1:0] snap_id;
        logic [PW-1:0]  snap_p;
        randomize_ops();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        n = 0;
        while (inflight != 2'd2 && n < 10) begin
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (acc_vec[i]) set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            n++;
        end
        snap_id = rsp_id;
        snap_p  = rsp_p;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (inflight !== 2'd2) begin errors++; $display("FAIL bp_inflight c=%0d: got %0d expected 2", c, inflight); end
            checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready c=%0d: got %b expected 0000", c, req_ready); end
            checks++;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid c=%0d: got %0b expected 1", c, rsp_valid); end
            checks++;
            if (rsp_id !== snap_id || rsp_p !== snap_p) begin
                errors++;
                $display("FAIL bp_stable c=%0d: got id=%0d p=%0d expected id=%0d p=%0d", c, rsp_id, rsp_p, snap_id, snap_p);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic send_single(input string name, input int id, input logic [7:0] a, input logic [7:0] b,
                               input logic [PW-1:0] exp_p);
        int n;
        bit seen;
        rsp_ready = 1'b1;
        set_op(id, a, b);
        req_valid = 4'(1 << id);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            seen = req_ready[id];
            next_cycle();
            n++;
        end
        req_valid = '0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            seen = rsp_valid;
            if (!seen) next_cycle();
            n++;
        end
        checks++;
        if (!seen || rsp_p !== exp_p || rsp_id !== 2'(id)) begin
            errors++;
            $display("FAIL %s: got valid=%0b id=%0d p=%0d expected valid=1 id=%0d p=%0d", name, seen, rsp_id, rsp_p, id, exp_p);
        end
        next_cycle();
        drain();
    endtask

    task automatic test_product();
        send_single("product_100x37", 1, 8'd100, 8'd37, 16'd3584);
        send_single("product_255x255", 2, 8'd255, 8'd255, 16'd63488);
    endtask

    task automatic test_zero_operand();
`ifdef ALM_ZERO_SKIP_EN
        send_single("zero_a0_b45", 3, 8'd0, 8'd45, 16'd0);
`else
        send_single("zero_a0_b45", 3, 8'd0, 8'd45, 16'd46);
`endif
    endtask

    task automatic test_sparse();
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            req_valid = 4'b0100;
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0100 || inflight > 2'd1) begin
                errors++;
                $display("FAIL sparse_accept k=%0d: got ready=%b inflight=%0d expected ready=0100 inflight<=1", k, req_ready, inflight);
            end
            next_cycle();
            req_valid = '0;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                checks++;
                if (inflight > 2'd1) begin errors++; $display("FAIL sparse_inflight k=%0d: got %0d expected <=1", k, inflight); end
                next_cycle();
            end
        end
        // rr_ptr must now sit at 3
        randomize_ops();
        req_valid = 4'hF;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_rr_ptr: got ready=%b expected 1000", req_ready); end
        next_cycle();
        drain();
    endtask

    task automatic test_back_to_back();
        int wait_acc[NREQ];
        for (int i = 0; i < NREQ; i++) wait_acc[i] = 0;
        req_valid = '0;
        for (int c = 0; c < 300; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    req_valid[i] = 1'b1;
                    wait_acc[i] = 0;
                end
            end
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (acc_vec[i]) begin
                    checks++;
                    if (wait_acc[i] > NREQ - 1) begin
                        errors++;
                        $display("FAIL fairness req=%0d: waited %0d accepts, expected <= %0d", i, wait_acc[i], NREQ - 1);
                    end
                    wait_acc[i] = 0;
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && acc_vec != '0) begin
                    wait_acc[i]++;
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        int n;
        randomize_ops();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        n = 0;
        while (inflight != 2'd2 && n < 10) begin
            next_cycle();
            n++;
        end
        checks++;
        if (inflight !== 2'd2) begin errors++; $display("FAIL rst_mid_fill: got inflight=%0d expected 2", inflight); end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp_valid: got %0b expected 0", rsp_valid); end
        checks++;
        if (inflight !== 2'd0) begin errors++; $display("FAIL rst_mid_inflight: got %0d expected 0", inflight); end
        checks++;
        if (rsp_p !== 16'd0 || rsp_id !== 2'd0) begin errors++; $display("FAIL rst_mid_rsp_data: got id=%0d p=%0d expected 0/0", rsp_id, rsp_p); end
        next_cycle();
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_first_grant: got %b expected 0001", req_ready); end
        next_cycle();
        drain();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_product();
        test_zero_operand();
        test_sparse();
        test_back_to_back();
        test_reset_midstream();
        repeat (3) next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
